// File: rtl/sec_reg_bank_lock.sv
// sec_reg_bank_lock
//   A bank of NUM_REGS protected registers that is guarded by a key-based
//   LOCKED / UNLOCKED state machine. Each register carries a 2-bit
//   protection level:
//     0 read-only, 1 writable while unlocked, 2 write-once while unlocked,
//     3 read-only.
//   Wrong keys are counted. Violations raise a one-cycle alert pulse and set
//   alert_sticky.
//
// Optional feature (macro SEC_REG_LOCKOUT_EN):
//   When the macro is defined, MAX_FAILS consecutive wrong keys put the bank
//   into LOCKOUT for exactly LOCKOUT_CYCLES cycles. When the macro is not
//   defined, fail_cnt saturates at MAX_FAILS and the bank stays in LOCKED.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_in, key_valid     unlock key and its strobe
//   lock_req              relock strobe (wins over a same-cycle key)
//   lvl_wr_*              protection-level update
//   wr_valid / wr_ready   write request channel (wr_idx, wr_data)
//   resp_valid/resp_ready write response channel (resp_err)
//   regs_flat             register contents, reg i at [i*REG_WIDTH +: REG_WIDTH]
//   sec_state             00 LOCKED, 01 UNLOCKED, 10 LOCKOUT (debug view of the FSM)
//   fail_cnt              consecutive wrong keys
//   alert, alert_sticky   violation pulse and its latched copy
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The sender holds valid and its payload stable until that edge. Only
// one write can be outstanding, so wr_ready is the inverse of resp_valid.
module sec_reg_bank_lock #(
    parameter int                    NUM_REGS       = 4,
    parameter int                    REG_WIDTH      = 32,
    parameter int                    KEY_WIDTH      = 32,
    parameter logic [KEY_WIDTH-1:0]  ADMIN_KEY      = 32'hDEADBEEF,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 256,
    parameter int                    IDX_W          = $clog2(NUM_REGS),
    parameter int                    FC_W           = $clog2(MAX_FAILS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KEY_WIDTH-1:0]          key_in,
    input  logic                          key_valid,
    input  logic                          lock_req,
    input  logic                          lvl_wr_valid,
    input  logic [IDX_W-1:0]              lvl_wr_idx,
    input  logic [1:0]                    lvl_wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [REG_WIDTH-1:0]          wr_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_err,
    output logic [NUM_REGS*REG_WIDTH-1:0] regs_flat,
    output logic [1:0]                    sec_state,
    output logic [FC_W-1:0]               fail_cnt,
    output logic                          alert,
    output logic                          alert_sticky
);

`ifdef SEC_REG_LOCKOUT_EN
    localparam bit LOCKOUT_EN = 1'b1;
`else
    localparam bit LOCKOUT_EN = 1'b0;
`endif

    localparam int              LC_W     = $clog2(LOCKOUT_CYCLES);
    localparam logic [FC_W-1:0] FAIL_MAX = FC_W'(MAX_FAILS);
    localparam logic [LC_W-1:0] LC_LAST  = LC_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_LOCKOUT  = 2'b10
    } sec_state_e;

    sec_state_e           state;
    logic [LC_W-1:0]      lockout_cnt;
    logic [REG_WIDTH-1:0] regs    [NUM_REGS];
    logic [1:0]           level   [NUM_REGS];
    logic [NUM_REGS-1:0]  written;

    logic       key_ok, unlock_evt, key_fail_evt, lockout_key_evt;
    logic       wr_fire, wr_idx_ok, lvl_idx_ok, lvl_bad, wr_reject, alert_evt;
    logic [1:0] sel_level;
    logic       sel_written;

    assign key_ok          = (key_in == ADMIN_KEY);
    assign unlock_evt      = (state == ST_LOCKED) && key_valid && key_ok;
    assign key_fail_evt    = (state == ST_LOCKED) && key_valid && !key_ok;
    assign lockout_key_evt = (state == ST_LOCKOUT) && key_valid;

    assign wr_ready   = !resp_valid;
    assign wr_fire    = wr_valid && wr_ready;
    assign wr_idx_ok  = (32'(wr_idx) < NUM_REGS);
    assign lvl_idx_ok = (32'(lvl_wr_idx) < NUM_REGS);
    assign lvl_bad    = lvl_wr_valid && !((state == ST_UNLOCKED) && lvl_idx_ok);

    // Level and written flag of the addressed register. An out-of-range index
    // matches nothing and falls back to level 0, which is rejected anyway.
    always_comb begin
        sel_level   = 2'd0;
        sel_written = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                sel_level   = level[i];
                sel_written = written[i];
            end
        end
    end

    assign wr_reject = (state != ST_UNLOCKED) || !wr_idx_ok ||
                       (sel_level == 2'd0) || (sel_level == 2'd3) ||
                       ((sel_level == 2'd2) && sel_written);

    assign alert_evt = key_fail_evt || lockout_key_evt || lvl_bad ||
                       (wr_fire && wr_reject);

    // Security state machine, wrong-key counter and lockout timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOCKED;
            fail_cnt    <= '0;
            lockout_cnt <= '0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (unlock_evt) begin
                        state    <= ST_UNLOCKED;
                        fail_cnt <= '0;
                    end else if (key_fail_evt) begin
                        if (fail_cnt != FAIL_MAX)
                            fail_cnt <= fail_cnt + FC_W'(1);
                        if (LOCKOUT_EN && (fail_cnt == FAIL_MAX - FC_W'(1))) begin
                            state       <= ST_LOCKOUT;
                            lockout_cnt <= '0;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    // Keys are ignored here, so lock_req wins over a key in the same cycle.
                    if (lock_req)
                        state <= ST_LOCKED;
                end
                ST_LOCKOUT: begin
                    // LOCKOUT is held for cycles 0 .. LOCKOUT_CYCLES-1 of the timer.
                    if (lockout_cnt == LC_LAST) begin
                        state       <= ST_LOCKED;
                        fail_cnt    <= '0;
                        lockout_cnt <= '0;
                    end else begin
                        lockout_cnt <= lockout_cnt + LC_W'(1);
                    end
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end

    // Write response channel and alert outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            alert        <= 1'b0;
            alert_sticky <= 1'b0;
        end else begin
            if (wr_fire) begin
                resp_valid <= 1'b1;
                resp_err   <= wr_reject;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
            end
            alert        <= alert_evt;
            alert_sticky <= (alert_sticky && !unlock_evt) || alert_evt;
        end
    end

    // Register bank, protection levels and write-once flags. The register
    // commits in the transfer cycle, so a later relock cannot undo it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]  <= '0;
                level[i] <= 2'd1;
            end
            written <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (lvl_wr_valid && (state == ST_UNLOCKED) && (lvl_wr_idx == IDX_W'(i)))
                    level[i] <= lvl_wr_data;
                if (wr_fire && !wr_reject && (wr_idx == IDX_W'(i))) begin
                    regs[i] <= wr_data;
                    if (level[i] == 2'd2)
                        written[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*REG_WIDTH +: REG_WIDTH] = regs[g];
    end

    assign sec_state = state;

endmodule

// File: tb/tb_sec_reg_bank_lock.sv
// Directed bench for sec_reg_bank_lock. The DUT uses NUM_REGS=3, so the
// out-of-range index NUM_REGS still fits in the 2-bit index ports.
module tb_sec_reg_bank_lock;
    localparam int NR = 3;
    localparam int RW = 32;
    localparam int KW = 32;
    localparam int IW = $clog2(NR);
    localparam int FW = $clog2(3 + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [KW-1:0]   key_in;
    logic            key_valid, lock_req, lvl_wr_valid;
    logic [IW-1:0]   lvl_wr_idx;
    logic [1:0]      lvl_wr_data;
    logic            wr_valid, wr_ready;
    logic [IW-1:0]   wr_idx;
    logic [RW-1:0]   wr_data;
    logic            resp_valid, resp_ready, resp_err;
    logic [NR*RW-1:0] regs_flat;
    logic [1:0]      sec_state;
    logic [FW-1:0]   fail_cnt;
    logic            alert, alert_sticky;

    int checks = 0;
    int errors = 0;

    sec_reg_bank_lock #(.NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .lock_req(lock_req), .lvl_wr_valid(lvl_wr_valid), .lvl_wr_idx(lvl_wr_idx),
        .lvl_wr_data(lvl_wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_idx(wr_idx), .wr_data(wr_data), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_err(resp_err), .regs_flat(regs_flat),
        .sec_state(sec_state), .fail_cnt(fail_cnt), .alert(alert),
        .alert_sticky(alert_sticky)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic send_key(input logic [KW-1:0] k);
        key_in = k; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic send_write(input logic [IW-1:0] idx, input logic [RW-1:0] d);
        wr_idx = idx; wr_data = d; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic send_level(input logic [IW-1:0] idx, input logic [1:0] lv);
        lvl_wr_idx = idx; lvl_wr_data = lv; lvl_wr_valid = 1'b1;
        tick();
        lvl_wr_valid = 1'b0;
    endtask

    function automatic logic [RW-1:0] reg_at(input int i);
        return regs_flat[i*RW +: RW];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; key_in = '0; key_valid = 0; lock_req = 0; lvl_wr_valid = 0;
        lvl_wr_idx = '0; lvl_wr_data = '0; wr_valid = 0; wr_idx = '0; wr_data = '0;
        resp_ready = 1'b1;
        #12;
        checks++; if (sec_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", sec_state); end
        checks++; if (fail_cnt !== '0) begin errors++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs_flat); end
        checks++; if ({resp_valid, resp_err, wr_ready} !== 3'b001) begin errors++; $display("FAIL reset_resp: got %b expected 001", {resp_valid, resp_err, wr_ready}); end
        checks++; if ({alert, alert_sticky} !== 2'b00) begin errors++; $display("FAIL reset_alert: got %b expected 00", {alert, alert_sticky}); end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_locked_write();
        send_write(2'd0, 32'h12345678);
        checks++; if ({resp_valid, resp_err} !== 2'b11) begin errors++; $display("FAIL locked_write_resp: got %b expected 11", {resp_valid, resp_err}); end
        checks++; if ({alert, alert_sticky} !== 2'b11) begin errors++; $display("FAIL locked_write_alert: got %b expected 11", {alert, alert_sticky}); end
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL locked_write_regs: got %h expected 0", regs_flat); end
        tick();
        checks++; if ({resp_valid, wr_ready, alert} !== 3'b010) begin errors++; $display("FAIL locked_write_drain: got %b expected 010", {resp_valid, wr_ready, alert}); end
    endtask

    task automatic test_unlock_stall();
        send_key(32'hDEADBEEF);
        checks++; if (sec_state !== 2'b01) begin errors++; $display("FAIL unlock_state: got %b expected 01", sec_state); end
        checks++; if (alert_sticky !== 1'b0) begin errors++; $display("FAIL unlock_sticky_clear: got %b expected 0", alert_sticky); end
        resp_ready = 1'b0;
        send_write(2'd1, 32'hA5A5A5A5);
        for (int k = 0; k < 3; k++) begin
            checks++; if ({resp_valid, resp_err, wr_ready} !== 3'b100) begin errors++; $display("FAIL stall_cycle%0d: got %b expected 100", k, {resp_valid, resp_err, wr_ready}); end
            if (k < 2) tick();
        end
        checks++; if (reg_at(1) !== 32'hA5A5A5A5) begin errors++; $display("FAIL stall_reg1: got %h expected a5a5a5a5", reg_at(1)); end
        resp_ready = 1'b1;
        tick();
        checks++; if ({resp_valid, wr_ready} !== 2'b01) begin errors++; $display("FAIL stall_release: got %b expected 01", {resp_valid, wr_ready}); end
    endtask

    task automatic test_write_once();
        send_level(2'd2, 2'd2);
        checks++; if (alert !== 1'b0) begin errors++; $display("FAIL level_set_alert: got %b expected 0", alert); end
        send_write(2'd2, 32'h1);
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL once_first: got %b expected 10", {resp_valid, resp_err}); end
        tick();
        send_write(2'd2, 32'h2);
        checks++; if ({resp_valid, resp_err, alert} !== 3'b111) begin errors++; $display("FAIL once_second: got %b expected 111", {resp_valid, resp_err, alert}); end
        checks++; if (reg_at(2) !== 32'h1) begin errors++; $display("FAIL once_reg2: got %h expected 00000001", reg_at(2)); end
        tick();
        send_level(2'd0, 2'd0);
        send_write(2'd0, 32'hFFFF0000);
        checks++; if ({resp_err, reg_at(0)} !== {1'b1, 32'h0}) begin errors++; $display("FAIL readonly_reg0: got %b/%h expected 1/00000000", resp_err, reg_at(0)); end
        tick();
    endtask

    task automatic test_lock_priority();
        send_write(2'd3, 32'hCAFE0000);
        checks++; if ({resp_err, alert} !== 2'b11) begin errors++; $display("FAIL oob_write: got %b expected 11", {resp_err, alert}); end
        tick();
        send_level(2'd3, 2'd1);
        checks++; if (alert !== 1'b1) begin errors++; $display("FAIL oob_level_alert: got %b expected 1", alert); end
        // Write committed in the same cycle as a relock must stick.
        lock_req = 1'b1;
        send_write(2'd1, 32'h00000055);
        lock_req = 1'b0;
        checks++; if ({sec_state, resp_err} !== 3'b000) begin errors++; $display("FAIL relock_commit: got %b expected 000", {sec_state, resp_err}); end
        checks++; if (reg_at(1) !== 32'h55) begin errors++; $display("FAIL relock_reg1: got %h expected 00000055", reg_at(1)); end
        tick();
        send_key(32'hDEADBEEF);
        lock_req = 1'b1;
        send_key(32'hDEADBEEF);
        lock_req = 1'b0;
        checks++; if (sec_state !== 2'b00) begin errors++; $display("FAIL lock_wins: got %b expected 00", sec_state); end
    endtask

    task automatic test_fail_cnt();
`ifdef SEC_REG_LOCKOUT_EN
        int n;
        for (int i = 1; i <= 3; i++) begin
            send_key(32'h00000000 + 32'(i));
            checks++; if ({fail_cnt, alert} !== {FW'(i), 1'b1}) begin errors++; $display("FAIL wrong_key%0d: got %0d/%b expected %0d/1", i, fail_cnt, alert, i); end
        end
        checks++; if (sec_state !== 2'b10) begin errors++; $display("FAIL lockout_enter: got %b expected 10", sec_state); end
        n = 1;
        send_key(32'hDEADBEEF);
        n++;
        checks++; if ({sec_state, alert} !== 3'b101) begin errors++; $display("FAIL lockout_key_ignored: got %b expected 101", {sec_state, alert}); end
        while (n < 256) begin tick(); n++; end
        checks++; if (sec_state !== 2'b10) begin errors++; $display("FAIL lockout_last_cycle: got %b expected 10", sec_state); end
        tick();
        checks++; if ({sec_state, fail_cnt} !== {2'b00, FW'(0)}) begin errors++; $display("FAIL lockout_exit: got %b/%0d expected 00/0", sec_state, fail_cnt); end
`else
        for (int i = 1; i <= 5; i++) begin
            send_key(32'h00000000 + 32'(i));
            checks++; if ({fail_cnt, alert} !== {FW'((i > 3) ? 3 : i), 1'b1}) begin errors++; $display("FAIL wrong_key%0d: got %0d/%b expected %0d/1", i, fail_cnt, alert, (i > 3) ? 3 : i); end
        end
        checks++; if (sec_state !== 2'b00) begin errors++; $display("FAIL no_lockout_state: got %b expected 00", sec_state); end
`endif
        send_key(32'hDEADBEEF);
        checks++; if ({sec_state, fail_cnt, alert_sticky} !== {2'b01, FW'(0), 1'b0}) begin errors++; $display("FAIL relock_unlock: got %b/%0d/%b expected 01/0/0", sec_state, fail_cnt, alert_sticky); end
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        send_write(2'd1, 32'h77777777);
        @(negedge clk); rst_n = 1'b0;
        #2;
        checks++; if ({resp_valid, wr_ready, sec_state} !== 4'b0100) begin errors++; $display("FAIL mid_reset_resp: got %b expected 0100", {resp_valid, wr_ready, sec_state}); end
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL mid_reset_regs: got %h expected 0", regs_flat); end
        @(negedge clk); rst_n = 1'b1; resp_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_locked_write();
        test_unlock_stall();
        test_write_once();
        test_lock_priority();
        test_fail_cnt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sec_reg_bank_lock.md
SEC_REG_BANK_LOCK -- requirements
Module: sec_reg_bank_lock

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_REGS, 4, protected registers, >=2.
- REG_WIDTH, 32, register width.
- KEY_WIDTH, 32, key width.
- ADMIN_KEY, 32'hDEADBEEF, unlock key.
- MAX_FAILS, 3, wrong keys before lockout, >=1.
- LOCKOUT_CYCLES, 256, lockout duration, >=2.
- IDX_W = $clog2(NUM_REGS); FC_W = $clog2(MAX_FAILS+1).
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk in 1 clock.
- rst_n in 1 reset.
- key_in in KEY_WIDTH key.
- key_valid in 1 key strobe.
- lock_req in 1 relock strobe.
- lvl_wr_valid in 1 level-update strobe.
- lvl_wr_idx in IDX_W level target.
- lvl_wr_data in 2 new level.
- wr_valid in 1 write request.
- wr_ready out 1 write accept.
- wr_idx in IDX_W write target.
- wr_data in REG_WIDTH write data.
- resp_valid out 1 response valid.
- resp_ready in 1 response accept.
- resp_err out 1 write rejected.
- regs_flat out NUM_REGS*REG_WIDTH registers, reg i at [i*REG_WIDTH +: REG_WIDTH].
- sec_state out 2 00=LOCKED, 01=UNLOCKED, 10=LOCKOUT.
- fail_cnt out FC_W consecutive wrong keys.
- alert out 1 one-cycle violation pulse.
- alert_sticky out 1 latched alert.
REQ-003 Reset SHALL be rst_n, asynchronous, active-low; clock SHALL be clk; all state SHALL update on the rising edge of clk.

Function
REQ-004 In LOCKED, key_valid with key_in==ADMIN_KEY SHALL move to UNLOCKED next cycle and clear fail_cnt.
REQ-005 In LOCKED, key_valid with a wrong key SHALL increment fail_cnt and pulse alert. When fail_cnt reaches MAX_FAILS, behaviour SHALL follow REQ-017/018.
REQ-006 In UNLOCKED, lock_req SHALL move to LOCKED next cycle. lock_req SHALL win over a same-cycle key_valid. key_valid in UNLOCKED SHALL be ignored.
REQ-007 Each register SHALL have a 2-bit level:
- 0 = read-only.
- 1 = writable while UNLOCKED.
- 2 = write-once while UNLOCKED; a per-register written flag sets on the first successful write.
- 3 = treated as 0.
REQ-008 lvl_wr_valid SHALL update level[lvl_wr_idx] only in UNLOCKED with lvl_wr_idx<NUM_REGS; otherwise it SHALL be ignored and SHALL pulse alert.
REQ-009 A write SHALL transfer when wr_valid && wr_ready. wr_ready SHALL be 1 exactly when no response is pending.
REQ-010 resp_valid SHALL assert the cycle after a transfer and hold, with resp_err stable, until resp_valid && resp_ready.
REQ-011 An accepted write SHALL be rejected (resp_err=1, register unchanged, alert pulsed) on any of:
- sec_state!=UNLOCKED;
- wr_idx>=NUM_REGS;
- level 0 or 3;
- level 2 with written flag set.
REQ-012 An accepted write that is not rejected SHALL update the register in the transfer cycle, visible on regs_flat the next cycle, with resp_err=0.
REQ-013 A transition UNLOCKED->LOCKED between a transfer and its response SHALL NOT revoke a write already committed.
REQ-014 alert_sticky SHALL set on any alert and clear only on reset or on a successful unlock.

Reset
REQ-015 On reset the block SHALL drive:
- sec_state=LOCKED;
- fail_cnt=0;
- all registers 0;
- all levels 1;
- written flags 0;
- resp_valid=0, resp_err=0;
- wr_ready=1;
- alert=0, alert_sticky=0;
- lockout counter 0.
REQ-016 Reset asserted mid-transaction SHALL discard the pending response and any in-progress lockout.

Configuration
REQ-017 With SEC_REG_LOCKOUT_EN defined:
- reaching MAX_FAILS SHALL enter LOCKOUT;
- LOCKOUT SHALL ignore key_valid, pulsing alert on each key_valid;
- after exactly LOCKOUT_CYCLES cycles in LOCKOUT the block SHALL return to LOCKED with fail_cnt=0.
REQ-018 Without SEC_REG_LOCKOUT_EN:
- LOCKOUT SHALL be unreachable;
- fail_cnt SHALL saturate at MAX_FAILS;
- the block SHALL stay in LOCKED;
- a correct key SHALL still unlock.

Verification
REQ-019 Reset, then write reg0=0x12345678 while LOCKED -> resp_err=1, alert pulse, regs_flat all 0.
REQ-020 Key 0xDEADBEEF, then write reg1=0xA5A5A5A5 with resp_ready held low for 3 cycles -> wr_ready=0 and resp_valid held for 3 cycles, resp_err=0, reg1=0xA5A5A5A5.
REQ-021 Unlocked; set level[2]=2, then write reg2=0x1 then reg2=0x2 -> first resp_err=0, second resp_err=1, reg2=0x1.
REQ-022 With SEC_REG_LOCKOUT_EN, 3 wrong keys -> sec_state=LOCKOUT; a correct key during LOCKOUT is ignored; after 256 cycles sec_state=LOCKED and fail_cnt=0.
REQ-023 Without SEC_REG_LOCKOUT_EN, 5 wrong keys -> fail_cnt=3 and sec_state=LOCKED; a correct key -> UNLOCKED with fail_cnt=0 and alert_sticky=0.
REQ-024 lock_req and a correct key_valid in the same cycle while UNLOCKED -> sec_state=LOCKED; write to wr_idx=NUM_REGS -> resp_err=1.
